// File: rtl/sisa_mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Both the top and the timeout counter import these.
package sisa_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int STARVE_W        = 3;

endpackage

// File: rtl/arb_timeout_counter.sv
// Clearable, enabled up-counter for the BUSY-phase timeout.
// tc_o marks the TIMEOUT-th enabled cycle since the last clear.
module arb_timeout_counter
  import sisa_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so a stray enable can never wrap back to terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CNT_W'(TIMEOUT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory slave port between instruction fetch and load/store,
// with D-over-IF priority, a starvation guard and a per-transaction timeout.
module mem_port_arbiter
  import sisa_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic                  if_err,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic [STARVE_W-1:0]   starve_cnt_o
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                m_valid_q, m_valid_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic                grant_d, tmo_clr, tmo_tc;

  // IF is forced only when it is actually waiting and D has used up its allowance.
  assign grant_d = d_req && !(if_req && (starve_q == STARVE_W'(MAX_STARVE)));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_valid_d  = m_valid_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    tmo_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (grant_d) begin
          owner_d   = OWN_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          if (if_req && (starve_q != STARVE_W'(MAX_STARVE)))
            starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          owner_d   = OWN_IF;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
          starve_d  = '0;
        end
        if (grant_d || if_req) begin
          m_valid_d = 1'b1;
          tmo_clr   = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A completing ack beats a timeout reached in the same cycle.
        if (m_ack || tmo_tc) begin
          m_valid_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_err_d   = !m_ack;
            d_rdata_d = (m_ack && !m_we_q) ? m_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = !m_ack;
            if_rdata_d = m_ack ? m_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_valid_q  <= m_valid_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
    end
  end

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .en    (state_q == BUSY),
    .tc_o  (tmo_tc)
  );

  assign if_ack       = if_ack_q;
  assign if_err       = if_err_q;
  assign if_rdata     = if_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_err        = d_err_q;
  assign d_rdata      = d_rdata_q;
  assign m_valid      = m_valid_q;
  assign m_we         = m_we_q;
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign m_be         = m_be_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants/acks are queued as requests
// are issued and compared when the arbiter presents them on the slave or ack ports.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        if_ack, if_err, d_ack, d_err, m_valid, m_we;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [2:0]  starve_cnt_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .starve_cnt_o(starve_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          err;
    int          len;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b1;
  bit   chk_starve = 1'b0;
  bit   slave_mute = 1'b0;
  int   slave_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  // Slave model: acks after slave_wait extra cycles of m_valid.
  initial begin
    int wcnt = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_ack = 1'b0;
      if (m_valid && !slave_mute) begin
        if (wcnt == slave_wait) begin
          m_ack = 1'b1;
          m_rdata = m_we ? 32'hBAD0BAD0 : mem_rd(m_addr);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_mv = 1'b0;
    logic [2:0]  prev_st = '0;
    int          vlen = 0;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_valid && !prev_mv) begin
          vlen = 1;
          c_addr = m_addr; c_wdata = m_wdata; c_be = m_be; c_we = m_we;
          if (q.size() == 0) check("grant_unexpected", 1, 0);
          else begin
            check("grant_addr", m_addr, q[0].addr);
            check("grant_we", m_we, q[0].we);
            if (!q[0].is_d) check("if_be", m_be, 4'hF);
            if (!q[0].is_d && chk_starve) begin
              check("starve_pre", prev_st, 3'd4);
              check("starve_post", starve_cnt_o, 3'd0);
            end
          end
        end else if (m_valid && prev_mv) begin
          vlen++;
          check("m_hold", {m_we, m_be, m_addr, m_wdata}, {c_we, c_be, c_addr, c_wdata});
        end
        if (!m_valid && prev_mv && q.size() > 0 && q[0].len != 0)
          check("valid_len", vlen, q[0].len);
        if (if_ack || d_ack) begin
          check("ack_excl", if_ack & d_ack, 0);
          if (q.size() == 0) check("ack_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            check("ack_owner", d_ack, e.is_d);
            check("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
            check("ack_err", d_ack ? d_err : if_err, e.err);
          end
        end
      end
      prev_mv = m_valid;
      prev_st = starve_cnt_o;
    end
  end

  task automatic if_txn(input logic [31:0] addr, output int lat);
    bit done = 1'b0;
    lat = 0;
    if_addr = addr;
    if_req = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (if_ack) done = 1'b1;
    end
    if (!done) check("if_ack_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic d_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    bit done = 1'b0;
    d_we = we; d_addr = addr; d_wdata = wd; d_be = be;
    d_req = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (d_ack) done = 1'b1;
    end
    if (!done) check("d_ack_timeout", 0, 1);
    d_req = 1'b0;
  endtask

  function automatic exp_t mk(bit is_d, bit we, logic [31:0] a, logic [31:0] rd, bit err, int len);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = a; e.rdata = rd; e.err = err; e.len = len;
    return e;
  endfunction

  initial begin
    int lat;
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {if_ack, if_err, d_ack, d_err, m_valid, m_we, m_be, starve_cnt_o}, 0);
    check("rst_data", {if_rdata, d_rdata, m_addr, m_wdata}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // IF read alone, zero-wait slave.
    q.push_back(mk(0, 0, 32'h0, 32'h13, 0, 1));
    if_txn(32'h0, lat);
    check("if_latency", lat, 2);
    repeat (2) @(posedge clk); #1;

    // Simultaneous requests: D first, IF next.
    q.push_back(mk(1, 1, 32'h200, 32'h0, 0, 1));
    q.push_back(mk(0, 0, 32'h80, mem_rd(32'h80), 0, 1));
    fork
      d_txn(1, 32'h200, 32'h12345678, 4'hF);
      if_txn(32'h80, lat);
    join
    repeat (2) @(posedge clk); #1;

    // Starvation guard: four D grants, forced IF, then D again.
    chk_starve = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 32'h100, mem_rd(32'h100), 0, 1));
    q.push_back(mk(0, 0, 32'h40, mem_rd(32'h40), 0, 1));
    q.push_back(mk(1, 0, 32'h100, mem_rd(32'h100), 0, 1));
    fork
      repeat (5) d_txn(0, 32'h100, 32'h0, 4'hF);
      if_txn(32'h40, lat);
    join
    chk_starve = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("starve_idle", starve_cnt_o, 0);

    // D write with 3 wait states.
    slave_wait = 3;
    q.push_back(mk(1, 1, 32'h300, 32'h0, 0, 4));
    d_txn(1, 32'h300, 32'hDEADBEEF, 4'b0011);
    slave_wait = 0;
    repeat (2) @(posedge clk); #1;

    // Silent slave: timeout abort after 8 BUSY cycles.
    slave_mute = 1'b1;
    q.push_back(mk(1, 0, 32'h400, 32'h0, 1, 8));
    d_txn(0, 32'h400, 32'h0, 4'hF);
    slave_mute = 1'b0;
    repeat (2) @(posedge clk); #1;
    q.push_back(mk(0, 0, 32'h44, mem_rd(32'h44), 0, 1));
    if_txn(32'h44, lat);
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of BUSY.
    mon_en = 1'b0;
    slave_mute = 1'b1;
    if_addr = 32'h500;
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outs", {if_ack, if_err, d_ack, d_err, m_valid, m_we, m_be, starve_cnt_o}, 0);
    check("rst_async_addr", m_addr, 0);
    repeat (3) @(posedge clk); #1;
    check("rst_no_ack", {if_ack, d_ack}, 0);
    if_req = 1'b0;
    reset = 1'b0;
    slave_mute = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {if_ack, d_ack, m_valid}, 0);
    mon_en = 1'b1;
    q.push_back(mk(0, 0, 32'h48, mem_rd(32'h48), 0, 1));
    if_txn(32'h48, lat);
    check("post_rst_latency", lat, 2);
    repeat (3) @(posedge clk); #1;
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
